// File: rtl/spi_mem_arbiter_pkg.sv
// rtl/spi_mem_arbiter_pkg.sv - shared types and constants for the SPI/host memory arbiter
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   state_e                 : arbiter FSM states (IDLE, ACCESS, RESP)
//   OWN_SPI / OWN_HOST      : owner encodings
package spi_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OWN_SPI  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/spi_mem_arbiter_rr_arb2.sv
// rtl/spi_mem_arbiter_rr_arb2.sv - two-way round-robin requester selection
// Ports:
//   spi_req_i      : SPI-side request
//   host_req_i     : host-side request
//   last_owner_i   : requester granted most recently (OWN_SPI / OWN_HOST)
//   grant_valid_o  : at least one request is pending
//   grant_owner_o  : selected requester, valid when grant_valid_o is high
module rr_arb2
  import spi_mem_arbiter_pkg::*;
(
  input  logic spi_req_i,
  input  logic host_req_i,
  input  logic last_owner_i,
  output logic grant_valid_o,
  output logic grant_owner_o
);

  always_comb begin
    grant_valid_o = spi_req_i | host_req_i;
    grant_owner_o = last_owner_i;
    if (spi_req_i && host_req_i) begin
      // Contention: the side that did not win last time goes next.
      grant_owner_o = ~last_owner_i;
    end else if (host_req_i) begin
      grant_owner_o = OWN_HOST;
    end else if (spi_req_i) begin
      grant_owner_o = OWN_SPI;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - arbitrates SPI and host requesters onto one single-port memory
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   spi_req/rwb/add/wdata       : SPI request (rwb=1 read, 0 write)
//   spi_ack, spi_rdata          : SPI completion pulse and read result
//   host_req/rwb/add/wdata      : host request
//   host_ack, host_rdata        : host completion pulse and read result
//   mem_add, mem_data_in        : latched address / write data to memory
//   mem_rwb                     : memory strobe, 0 = write this cycle
//   mem_data_out                : combinational read data from memory
//   busy                        : FSM not IDLE
//   owner                       : current or last granted requester (0=SPI, 1=host)
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_req,
  input  logic              spi_rwb,
  input  logic [ADDR_W-1:0] spi_add,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  input  logic              host_req,
  input  logic              host_rwb,
  input  logic [ADDR_W-1:0] host_add,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rwb,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              owner
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rwb_q, rwb_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic grant_valid;
  logic grant_owner;

  rr_arb2 u_rr_arb2 (
    .spi_req_i     (spi_req),
    .host_req_i    (host_req),
    .last_owner_i  (owner_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  logic rd_resp;
  assign rd_resp = (state_q == RESP) && rwb_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rwb_d        = rwb_q;
    add_d        = add_q;
    wdata_d      = wdata_q;
    spi_rdata_d  = spi_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
          owner_d = grant_owner;
          // Snapshot the winner's request so later input changes cannot leak in.
          if (grant_owner == OWN_HOST) begin
            rwb_d   = host_rwb;
            add_d   = host_add;
            wdata_d = host_wdata;
          end else begin
            rwb_d   = spi_rwb;
            add_d   = spi_add;
            wdata_d = spi_wdata;
          end
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (rwb_q) begin
          if (owner_q == OWN_HOST) host_rdata_d = mem_data_out;
          else                     spi_rdata_d  = mem_data_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_HOST;
      rwb_q        <= 1'b1;
      add_q        <= '0;
      wdata_q      <= '0;
      spi_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rwb_q        <= rwb_d;
      add_q        <= add_d;
      wdata_q      <= wdata_d;
      spi_rdata_q  <= spi_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign mem_add     = add_q;
  assign mem_data_in = wdata_q;
  // Reset overrides the strobe immediately so a write caught mid-ACCESS never lands.
  assign mem_rwb     = reset | ~((state_q == ACCESS) & ~rwb_q);
  assign spi_ack     = ~reset & (state_q == RESP) & (owner_q == OWN_SPI);
  assign host_ack    = ~reset & (state_q == RESP) & (owner_q == OWN_HOST);
  // Read data is forwarded during the ack cycle and held in the register afterwards.
  assign spi_rdata   = (rd_resp && owner_q == OWN_SPI)  ? mem_data_out : spi_rdata_q;
  assign host_rdata  = (rd_resp && owner_q == OWN_HOST) ? mem_data_out : host_rdata_q;

endmodule
